// File: rtl/matrix_pkg.sv
// Shared constants and helpers for the LED-matrix display controller.
package matrix_pkg;

   // Pattern source selection on the MODE input
   localparam logic [1:0] MODE_LFSR  = 2'd0;
   localparam logic [1:0] MODE_COUNT = 2'd1;
   localparam logic [1:0] MODE_HOLD  = 2'd2;
   localparam logic [1:0] MODE_LOAD  = 2'd3;

   // Maximal-length feedback masks for the common matrix sizes
   localparam logic [15:0] TAPS_W16 = 16'hD008;
   localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000;

   // Bits needed to hold values 0..value-1 (never less than 1)
   function automatic int unsigned clog2w(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((w < 31) && ((32'd1 << w) < value)) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/matrix_pattern_gen.sv
// Pattern register for the display: LFSR / counter / hold / external load.
module matrix_pattern_gen
   import matrix_pkg::*;
#(
   parameter int unsigned  W    = 64,
   parameter logic [W-1:0] SEED = W'(1),
   parameter logic [W-1:0] TAPS = W'(TAPS_W64)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         step_tick_i,
   input  logic [1:0]   mode_i,
   input  logic         load_valid_i,
   input  logic [W-1:0] load_data_i,
   output logic         load_ready_o,
   output logic [W-1:0] pattern_o
);

   logic [W-1:0] pattern_q;
   logic [W-1:0] pattern_d;
   logic [W-1:0] lfsr_c;

   // Loads are accepted only while the external-load mode is selected
   assign load_ready_o = (mode_i == MODE_LOAD);
   assign pattern_o    = pattern_q;

   // Next pattern: load has priority in mode 3, otherwise advance on step_tick
   always_comb begin
      pattern_d = pattern_q;
      lfsr_c    = {pattern_q[W-2:0], ^(pattern_q & TAPS)};
      if (mode_i == MODE_LOAD) begin
         if (load_valid_i) begin
            pattern_d = load_data_i;
         end
      end else if (step_tick_i) begin
         case (mode_i)
            MODE_LFSR:  pattern_d = (lfsr_c == '0) ? SEED : lfsr_c;
            MODE_COUNT: pattern_d = pattern_q + W'(1);
            default:    pattern_d = pattern_q;
         endcase
      end
   end

   // Pattern register, restarts from SEED
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern_q <= SEED;
      end else begin
         pattern_q <= pattern_d;
      end
   end

endmodule

// File: rtl/matrix_display_ctrl.sv
// LED-matrix display controller: prescaler, pattern source, tear-free frame
// buffer and row scanner. Optional anti-ghosting blanking via MATRIX_BLANK_EN.
module matrix_display_ctrl
   import matrix_pkg::*;
#(
   parameter int unsigned                  N_ROWS       = 8,
   parameter int unsigned                  N_COLS       = 8,
   parameter int unsigned                  SCAN_DIV     = 16,
   parameter int unsigned                  STEP_DIV     = 22,
   parameter logic [N_ROWS*N_COLS-1:0]     SEED         = (N_ROWS*N_COLS)'(1),
   parameter logic [N_ROWS*N_COLS-1:0]     TAPS         = (N_ROWS*N_COLS)'(TAPS_W64),
   parameter int unsigned                  BLANK_CYCLES = 4
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic [1:0]               MODE,
   input  logic                     LOAD_VALID,
   input  logic [N_ROWS*N_COLS-1:0] LOAD_DATA,
   output logic                     LOAD_READY,
   output logic [N_ROWS-1:0]        ROWS,
   output logic [N_COLS-1:0]        COLUMNS,
   output logic                     FRAME_END,
   output logic [1:0]               ACT_LEDS
);

   localparam int unsigned W  = N_ROWS * N_COLS;
   localparam int unsigned PW = (SCAN_DIV > STEP_DIV) ? SCAN_DIV : STEP_DIV;
   localparam int unsigned RW = clog2w(N_ROWS);

   logic [PW-1:0]     presc_q,     presc_d;
   logic [RW-1:0]     row_idx_q,   row_idx_d;
   logic [W-1:0]      frame_q,     frame_d;
   logic [N_ROWS-1:0] row_sel_q,   row_sel_d;
   logic [N_COLS-1:0] col_sel_q,   col_sel_d;
   logic              frame_end_q, frame_end_d;
   logic [1:0]        leds_q,      leds_d;

   logic              scan_tick_c;
   logic              step_tick_c;
   logic              wrap_c;
   logic [W-1:0]      pattern;
   logic [N_COLS-1:0] frame_row_c [N_ROWS];

   assign scan_tick_c = &presc_q[SCAN_DIV-1:0];
   assign step_tick_c = &presc_q[STEP_DIV-1:0];
   assign wrap_c      = scan_tick_c && (row_idx_q == RW'(N_ROWS - 1));

   // Split the frame buffer into per-row column words
   for (genvar r = 0; r < N_ROWS; r++) begin : g_frame_rows
      assign frame_row_c[r] = frame_q[r*N_COLS +: N_COLS];
   end

   matrix_pattern_gen #(
      .W    (W),
      .SEED (SEED),
      .TAPS (TAPS)
   ) u_pattern_gen (
      .clk          (CLK),
      .rst_n        (RESET_N),
      .step_tick_i  (step_tick_c),
      .mode_i       (MODE),
      .load_valid_i (LOAD_VALID),
      .load_data_i  (LOAD_DATA),
      .load_ready_o (LOAD_READY),
      .pattern_o    (pattern)
   );

   // Scanner, frame capture at the frame boundary and activity LEDs
   always_comb begin
      presc_d     = presc_q + PW'(1);
      row_idx_d   = row_idx_q;
      frame_d     = frame_q;
      row_sel_d   = row_sel_q;
      col_sel_d   = col_sel_q;
      frame_end_d = wrap_c;
      leds_d      = leds_q;
      if (scan_tick_c) begin
         row_sel_d = N_ROWS'(1) << row_idx_q;
         col_sel_d = ~frame_row_c[row_idx_q];
         row_idx_d = wrap_c ? '0 : row_idx_q + RW'(1);
      end
      if (wrap_c) begin
         // Last row is still driven from the old frame; the new one starts at row 0
         frame_d   = pattern;
         leds_d[1] = ~leds_q[1];
      end
      if (step_tick_c) begin
         leds_d[0] = ~leds_q[0];
      end
   end

   // Scanner state registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         presc_q     <= '0;
         row_idx_q   <= '0;
         frame_q     <= '0;
         row_sel_q   <= '0;
         col_sel_q   <= '1;
         frame_end_q <= 1'b0;
         leds_q      <= 2'b11;
      end else begin
         presc_q     <= presc_d;
         row_idx_q   <= row_idx_d;
         frame_q     <= frame_d;
         row_sel_q   <= row_sel_d;
         col_sel_q   <= col_sel_d;
         frame_end_q <= frame_end_d;
         leds_q      <= leds_d;
      end
   end

   assign FRAME_END = frame_end_q;
   assign ACT_LEDS  = leds_q;

`ifdef MATRIX_BLANK_EN
   localparam int unsigned BW = clog2w(BLANK_CYCLES + 1);

   if (64'(BLANK_CYCLES) >= (64'(1) << SCAN_DIV)) begin : g_blank_chk
      $error("BLANK_CYCLES must be smaller than the row period 2**SCAN_DIV");
   end

   logic [BW-1:0]     blank_q,    blank_d;
   logic [N_ROWS-1:0] rows_out_q, rows_out_d;
   logic [N_COLS-1:0] cols_out_q, cols_out_d;

   // Blank the matrix for BLANK_CYCLES cycles after every row change
   always_comb begin
      blank_d    = blank_q;
      rows_out_d = row_sel_d;
      cols_out_d = col_sel_d;
      if (scan_tick_c) begin
         blank_d = BW'(BLANK_CYCLES);
      end else if (blank_q != '0) begin
         blank_d = blank_q - BW'(1);
      end
      if (blank_d != '0) begin
         rows_out_d = '0;
         cols_out_d = '1;
      end
   end

   // Blanked output registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         blank_q    <= '0;
         rows_out_q <= '0;
         cols_out_q <= '1;
      end else begin
         blank_q    <= blank_d;
         rows_out_q <= rows_out_d;
         cols_out_q <= cols_out_d;
      end
   end

   assign ROWS    = rows_out_q;
   assign COLUMNS = cols_out_q;
`else
   assign ROWS    = row_sel_q;
   assign COLUMNS = col_sel_q;
`endif

endmodule

// File: doc/matrix_display_ctrl.md
Name: matrix_display_ctrl

Overview:
Parametrised LED-matrix display controller: prescaler, pattern source, tear-free frame buffer and row scanner in one block. Generalises the fixed 8x8 LFSR display to N_ROWS x N_COLS. Adds selectable pattern modes (LFSR, counter, hold, external load) and a frame-end handshake. Sits at top level, driving the matrix row/column pins and the activity LEDs directly.

Parameters:
N_ROWS, 8, matrix rows (>=2)
N_COLS, 8, matrix columns (>=1); W = N_ROWS*N_COLS
SCAN_DIV, 16, row advances every 2^SCAN_DIV CLK cycles
STEP_DIV, 22, pattern steps every 2^STEP_DIV CLK cycles
SEED, 'h1 (W bits), pattern reset/reload value; must be non-zero
TAPS, 64'hD800000000000000, LFSR feedback mask (W bits)
BLANK_CYCLES, 4, blanking length (only with MATRIX_BLANK_EN)

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
MODE  in  2  0 LFSR, 1 counter, 2 hold, 3 external load
LOAD_VALID  in  1  load request (mode 3)
LOAD_DATA  in  W  pattern to load; bit r*N_COLS+c = row r, col c
LOAD_READY  out  1  high iff MODE==3
ROWS  out  N_ROWS  one-hot active-high row select
COLUMNS  out  N_COLS  active-low column drive
FRAME_END  out  1  one-cycle pulse when the last row's period ends
ACT_LEDS  out  2  active-low: [0] step heartbeat, [1] frame toggle

Behaviour:
- Reset (async, RESET_N=0): prescaler 0, row_idx 0, pattern=SEED, frame=0, ROWS=0, COLUMNS=all 1, FRAME_END=0, ACT_LEDS=2'b11.
- Prescaler: free-running counter, width max(SCAN_DIV,STEP_DIV). scan_tick = low SCAN_DIV bits all ones; step_tick = low STEP_DIV bits all ones. Each is a 1-cycle strobe.
- Scanner: on scan_tick, row_idx increments; N_ROWS-1 wraps to 0. FRAME_END=1 in the cycle after the wrapping tick.
- Frame buffer: on the wrapping scan_tick, frame <= pattern. Pattern changes never appear mid-frame.
- Outputs are registered, 1-cycle latency after scan_tick: ROWS = 1<<row_idx; COLUMNS = ~frame[row_idx*N_COLS +: N_COLS]. ROWS stays 0 until the first scan_tick.
- Pattern, on step_tick:
  - mode 0: pattern <= {pattern[W-2:0], ^(pattern & TAPS)}. If the result is 0, reload SEED.
  - mode 1: pattern <= pattern+1, wrapping modulo 2^W; no zero reload.
  - mode 2: unchanged.
  - mode 3: step_tick ignored. LOAD_VALID && LOAD_READY loads LOAD_DATA at the next edge. Back-to-back loads are allowed; the last load before the frame boundary is the one displayed.
  - Load and the wrapping scan_tick in the same cycle: the frame copies the old pattern; the new pattern shows next frame.
- MODE is sampled each cycle. A change takes effect at the next step_tick (modes 0-2) or immediately (LOAD_READY). No pattern reset on mode change.
- ACT_LEDS[0] toggles on each step_tick. ACT_LEDS[1] toggles on each FRAME_END.
- RESET_N low mid-frame: outputs blank immediately (async). After release, scanning restarts from row 0 with frame=0.

Optional Feature:
MATRIX_BLANK_EN
- Defined: after every scan_tick, ROWS=0 and COLUMNS=all 1 for BLANK_CYCLES cycles (anti-ghosting), then the new row is driven. FRAME_END timing is unchanged. Requires BLANK_CYCLES < 2^SCAN_DIV; violation is an elaboration error.
- Undefined: rows switch immediately; BLANK_CYCLES is ignored.

Decomposition:
- Package matrix_pkg: MODE_LFSR/MODE_COUNT/MODE_HOLD/MODE_LOAD constants (2-bit), default TAPS constants for W=16 (16'hD008) and W=64, and a clog2-style width function.
- One sub-module: matrix_pattern_gen, containing the pattern register, mode logic, load handshake and zero-reload.
- Scanner, prescaler and frame buffer stay in the top.

Test Plan:
(Bench parameters: N_ROWS=N_COLS=4, SCAN_DIV=2, STEP_DIV=4, SEED=16'h0001, TAPS=16'hD008.)
1. Reset: RESET_N=0 for 5 cycles -> ROWS=0, COLUMNS=4'hF, ACT_LEDS=2'b11, FRAME_END=0. With MODE=0, LOAD_READY=0.
2. Scan, MODE=2: ROWS sequence 1,2,4,8,1, each held 4 cycles. FRAME_END pulses every 16 cycles. ACT_LEDS[1] toggles per frame.
3. Load: MODE=3, LOAD_DATA=16'hA5C3, one-cycle LOAD_VALID (LOAD_READY=1). After the next FRAME_END, COLUMNS = 4'hC/4'h3/4'hA/4'h5 for ROWS = 1/2/4/8.
4. LFSR, MODE=0 from reset: pattern after step ticks 1-4 = 16'h0002, 16'h0004, 16'h0008, 16'h0011. ACT_LEDS[0] toggles every 16 cycles.
5. Counter wrap: load 16'hFFFF, then MODE=1 -> after one step_tick pattern=16'h0000 (no SEED reload). The next step gives 16'h0001.
6. Async reset mid-row: drop RESET_N while ROWS=4 -> ROWS=0 and COLUMNS=4'hF with no clock edge. After release, the first lit row is ROWS=1.
